// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader
//   Drains a show-ahead-less FIFO (1-cycle read latency) into a valid/ready
//   packet stream. Each returned word is checked against SOP/EOP framing.
//   Words that arrive outside a packet are dropped. A new SOP inside a
//   packet is kept, but it is counted as an error.
//
// Ports
//   Clock      : single clock, rising edge
//   Reset      : synchronous, active-high
//   FifoQ      : FIFO read data {SOP, EOP, payload[15:0]}
//   FifoEmpty  : FIFO empty flag
//   FifoRdEn   : FIFO read strobe; data returns on FifoQ one cycle later
//   OutData    : stream payload (head of the output buffer)
//   OutSop     : first word of packet
//   OutEop     : last word of packet
//   OutValid   : stream word valid
//   OutReady   : downstream accepts the word
//   PktCount   : number of accepted EOP words, wraps
//   ErrCount   : number of framing errors, wraps
module fifo_pkt_reader #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [17:0]          FifoQ,
  input  logic                 FifoEmpty,
  output logic                 FifoRdEn,
  output logic [15:0]          OutData,
  output logic                 OutSop,
  output logic                 OutEop,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [CNT_WIDTH-1:0] PktCount,
  output logic [CNT_WIDTH-1:0] ErrCount
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t      state, state_nxt;

  // infl: the read issued last cycle, whose data is on FifoQ now.
  logic        infl;
  logic [1:0]  occ;
  logic [1:0]  wr_ptr, rd_ptr;
  logic [17:0] entries [3];

  logic        push, pop, err_inc;
  logic        word_sop, word_eop;
  logic [17:0] head;

  assign word_sop = FifoQ[17];
  assign word_eop = FifoQ[16];

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Every word that can land in the buffer is counted: occ plus the read in
  // flight. So the buffer can never overflow, whatever OutReady does. OutReady
  // is deliberately left out, which keeps the FIFO strobe off the downstream
  // timing path.
  assign FifoRdEn = !Reset && !FifoEmpty && (({1'b0, occ} + {2'b00, infl}) < 3'd3);

  assign head     = entries[rd_ptr];
  assign OutValid = (occ != 2'd0);
  assign OutData  = OutValid ? head[15:0] : 16'h0000;
  assign OutSop   = OutValid & head[17];
  assign OutEop   = OutValid & head[16];
  assign pop      = OutValid && OutReady;

  // Framing decision for the word returning this cycle.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    err_inc   = 1'b0;
    if (infl) begin
      unique case (state)
        IDLE: begin
          if (word_sop) begin
            push      = 1'b1;
            state_nxt = word_eop ? IDLE : IN_PKT;
          end else begin
            err_inc   = 1'b1;          // orphan word, dropped
          end
        end
        IN_PKT: begin
          push      = 1'b1;
          err_inc   = word_sop;        // earlier packet truncated by a new SOP
          state_nxt = word_eop ? IDLE : IN_PKT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      infl     <= 1'b0;                // drops data from a read issued before reset
      occ      <= 2'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      PktCount <= '0;
      ErrCount <= '0;
    end else begin
      state <= state_nxt;
      infl  <= FifoRdEn;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
      if (pop && head[16]) PktCount <= PktCount + CNT_WIDTH'(1);
      if (err_inc)         ErrCount <= ErrCount + CNT_WIDTH'(1);
    end
  end

  // Buffer storage; the contents do not matter while occ says the slot is empty.
  always_ff @(posedge Clock) begin
    if (!Reset && push) entries[wr_ptr] <= FifoQ;
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader. The bench models the FIFO as a queue with a
// 1-cycle read latency. A reference model applies the framing rules to each
// word as it returns. It also predicts the expected stream, the counters, the
// buffer occupancy and the read strobe.
module tb_fifo_pkt_reader;
  localparam int CW = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [17:0]   FifoQ = '0;
  logic          FifoEmpty = 1'b1;
  logic          FifoRdEn;
  logic [15:0]   OutData;
  logic          OutSop, OutEop, OutValid;
  logic          OutReady = 1'b0;
  logic [CW-1:0] PktCount, ErrCount;

  always #5 Clock = ~Clock;

  fifo_pkt_reader #(.CNT_WIDTH(CW)) dut (
    .Clock(Clock), .Reset(Reset), .FifoQ(FifoQ), .FifoEmpty(FifoEmpty),
    .FifoRdEn(FifoRdEn), .OutData(OutData), .OutSop(OutSop), .OutEop(OutEop),
    .OutValid(OutValid), .OutReady(OutReady), .PktCount(PktCount), .ErrCount(ErrCount)
  );

  typedef struct packed { logic [15:0] d; logic s; logic e; } word_t;

  logic [17:0] q[$];          // FIFO contents
  word_t       exp_q[$];      // words the DUT should hold / deliver, in order
  logic [15:0] got[$];
  int          acc_cyc[$];
  int          npass = 0, ntot = 0;
  int          exp_pkt = 0, exp_err = 0, cyc = 0, rd_seen = 0;
  bit          in_pkt = 0, pend = 0, prev_stall = 0, rand_ready = 0;
  word_t       prev_head;

  task automatic push_word(input logic [17:0] w);
    q.push_back(w);
    FifoEmpty = 1'b0;
  endtask

  // Framing rules applied to a word coming back from the FIFO.
  task automatic model_word(input logic [17:0] w);
    if (!w[17] && !in_pkt) exp_err++;
    else begin
      if (w[17] && in_pkt) exp_err++;
      exp_q.push_back(word_t'({w[15:0], w[17], w[16]}));
      in_pkt = !w[16];
    end
  endtask

  // One clock: check outputs at the negedge, then advance the FIFO and the model.
  task automatic step();
    word_t head;
    bit    rd, rst;
    int    held;
    @(negedge Clock);
    rd   = FifoRdEn;
    rst  = Reset;
    head = word_t'({OutData, OutSop, OutEop});
    held = exp_q.size() + int'(pend);
    ntot++;
    if (FifoRdEn !== (!rst && !FifoEmpty && held < 3)) begin
      $display("FAIL rd_en cyc %0d: got %b want %b", cyc, FifoRdEn, (!rst && !FifoEmpty && held < 3));
    end else npass++;
    ntot++;
    if (OutValid !== (exp_q.size() != 0)) begin
      $display("FAIL out_valid cyc %0d: got %b want %b", cyc, OutValid, (exp_q.size() != 0));
    end else npass++;
    ntot++;
    if (PktCount !== CW'(exp_pkt)) begin
      $display("FAIL pkt_count cyc %0d: got %0d want %0d", cyc, PktCount, CW'(exp_pkt));
    end else npass++;
    ntot++;
    if (ErrCount !== CW'(exp_err)) begin
      $display("FAIL err_count cyc %0d: got %0d want %0d", cyc, ErrCount, CW'(exp_err));
    end else npass++;
    if (prev_stall) begin
      ntot++;
      if (head !== prev_head) $display("FAIL head_stable cyc %0d: got %h want %h", cyc, head, prev_head);
      else npass++;
    end
    if (OutValid === 1'b1 && OutReady === 1'b1) begin
      ntot++;
      if (exp_q.size() == 0) $display("FAIL extra_word cyc %0d: got %h want none", cyc, head);
      else begin
        if (head !== exp_q[0]) $display("FAIL out_word cyc %0d: got %h want %h", cyc, head, exp_q[0]);
        else npass++;
        if (exp_q[0].e) exp_pkt++;
        void'(exp_q.pop_front());
      end
      got.push_back(OutData);
      acc_cyc.push_back(cyc);
    end
    prev_stall = (OutValid === 1'b1) && (OutReady === 1'b0);
    prev_head  = head;
    if (rd) rd_seen++;
    @(posedge Clock);
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_pkt = 0; exp_err = 0; in_pkt = 0; prev_stall = 0;
    end else if (pend) model_word(FifoQ);
    pend = rd && !rst;
    if (rd && q.size() != 0) FifoQ = q.pop_front();
    FifoEmpty = (q.size() == 0);
    if (rand_ready) OutReady = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || q.size() != 0 || pend) && n < max_cyc) begin
      step();
      n++;
    end
    step();
    ntot++;
    if (n >= max_cyc) $display("FAIL drain_timeout: got %0d cycles want < %0d", n, max_cyc);
    else npass++;
  endtask

  task automatic do_reset();
    rand_ready = 0;
    OutReady   = 1'b0;
    Reset      = 1'b1;
    step();
    step();
    Reset = 1'b0;
    got.delete();
    acc_cyc.delete();
    rd_seen = 0;
  endtask

  task automatic test_reset();
    push_word({2'b11, 16'h0055});
    step();                                  // Reset high with FIFO non-empty
    ntot++; if (OutValid !== 1'b0) $display("FAIL rst_valid: got %b want 0", OutValid); else npass++;
    ntot++; if ({OutData, OutSop, OutEop} !== 18'h0) $display("FAIL rst_data: got %h want 0", {OutData, OutSop, OutEop}); else npass++;
    ntot++; if (FifoRdEn !== 1'b0) $display("FAIL rst_rden: got %b want 0", FifoRdEn); else npass++;
    ntot++; if (PktCount !== '0 || ErrCount !== '0) $display("FAIL rst_cnt: got %0d/%0d want 0/0", PktCount, ErrCount); else npass++;
    Reset = 1'b0;
    #1;
    ntot++; if (FifoRdEn !== 1'b1) $display("FAIL first_rden: got %b want 1", FifoRdEn); else npass++;
    OutReady = 1'b1;
    drain(50);
    ntot++; if (got.size() != 1 || got[0] !== 16'h0055) $display("FAIL rst_first_pkt: got %0d words want 1 word 0055", got.size()); else npass++;
  endtask

  task automatic test_stream();
    do_reset();
    OutReady = 1'b1;
    push_word({2'b10, 16'h0001});
    push_word({2'b00, 16'h0002});
    push_word({2'b01, 16'h0003});
    drain(50);
    ntot++;
    if (got.size() != 3 || got[0] !== 16'h1 || got[1] !== 16'h2 || got[2] !== 16'h3)
      $display("FAIL stream_data: got %0d words want 1,2,3", got.size());
    else npass++;
    ntot++;
    if (acc_cyc.size() != 3 || acc_cyc[2] - acc_cyc[0] != 2)
      $display("FAIL stream_consecutive: got %0d words want 3 consecutive", acc_cyc.size());
    else npass++;
    ntot++; if (PktCount !== CW'(1) || ErrCount !== '0) $display("FAIL stream_cnt: got %0d/%0d want 1/0", PktCount, ErrCount); else npass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++)
      push_word({(i == 0), (i == 9), 16'(16'h0100 + i)});
    repeat (8) step();
    ntot++; if (rd_seen != 3) $display("FAIL bp_reads: got %0d want 3", rd_seen); else npass++;
    ntot++; if (OutData !== 16'h0100) $display("FAIL bp_head: got %h want 0100", OutData); else npass++;
    OutReady = 1'b1;
    drain(100);
    ntot++;
    if (got.size() != 10) $display("FAIL bp_count: got %0d want 10", got.size());
    else begin
      for (int i = 0; i < 10; i++)
        if (got[i] !== 16'(16'h0100 + i)) begin
          $display("FAIL bp_order idx %0d: got %h want %h", i, got[i], 16'(16'h0100 + i));
          ntot++;
        end
      npass++;
    end
    ntot++; if (PktCount !== CW'(1)) $display("FAIL bp_pkt: got %0d want 1", PktCount); else npass++;
  endtask

  task automatic test_framing();
    do_reset();
    OutReady = 1'b1;
    push_word({2'b00, 16'h00AA});
    push_word({2'b11, 16'h00BB});
    drain(50);
    ntot++; if (got.size() != 1 || got[0] !== 16'h00BB) $display("FAIL frame_data: got %0d words want only 00BB", got.size()); else npass++;
    ntot++; if (ErrCount !== CW'(1) || PktCount !== CW'(1)) $display("FAIL frame_cnt: got %0d/%0d want err1/pkt1", ErrCount, PktCount); else npass++;
  endtask

  task automatic test_truncation();
    do_reset();
    OutReady = 1'b1;
    push_word({2'b10, 16'h0010});
    push_word({2'b00, 16'h0011});
    push_word({2'b10, 16'h0020});
    push_word({2'b01, 16'h0021});
    drain(50);
    ntot++;
    if (got.size() != 4 || got[0] !== 16'h10 || got[1] !== 16'h11 || got[2] !== 16'h20 || got[3] !== 16'h21)
      $display("FAIL trunc_data: got %0d words want 10,11,20,21", got.size());
    else npass++;
    ntot++; if (ErrCount !== CW'(1) || PktCount !== CW'(1)) $display("FAIL trunc_cnt: got %0d/%0d want err1/pkt1", ErrCount, PktCount); else npass++;
    // back in IDLE: an orphan word must be dropped and counted
    push_word({2'b00, 16'h0044});
    drain(50);
    ntot++; if (got.size() != 4 || ErrCount !== CW'(2)) $display("FAIL trunc_idle: got %0d words err %0d want 4 words err 2", got.size(), ErrCount); else npass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++)
      push_word({(i == 0), (i == 9), 16'(16'h0200 + i)});
    repeat (3) step();                       // occ=2 with one read in flight
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    q.delete();
    FifoEmpty = 1'b1;
    ntot++; if (OutValid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", OutValid); else npass++;
    ntot++; if (PktCount !== '0 || ErrCount !== '0) $display("FAIL midrst_cnt: got %0d/%0d want 0/0", PktCount, ErrCount); else npass++;
    step();
    ntot++; if (OutValid !== 1'b0) $display("FAIL midrst_discard: got %b want 0", OutValid); else npass++;
    OutReady = 1'b1;
    push_word({2'b10, 16'h0071});
    push_word({2'b00, 16'h0072});
    push_word({2'b01, 16'h0073});
    drain(50);
    ntot++;
    if (got.size() != 3 || got[0] !== 16'h71 || got[2] !== 16'h73)
      $display("FAIL midrst_pkt: got %0d words want 71,72,73", got.size());
    else npass++;
    ntot++; if (PktCount !== CW'(1) || ErrCount !== '0) $display("FAIL midrst_after: got %0d/%0d want 1/0", PktCount, ErrCount); else npass++;
  endtask

  task automatic test_wrap();
    do_reset();
    rand_ready = 1;
    for (int i = 0; i < 16; i++) push_word({2'b11, 16'(i)});
    drain(300);
    ntot++; if (got.size() != 16) $display("FAIL wrap_words: got %0d want 16", got.size()); else npass++;
    ntot++; if (PktCount !== '0) $display("FAIL wrap_pkt: got %0d want 0", PktCount); else npass++;
  endtask

  task automatic test_random();
    logic [17:0] w;
    do_reset();
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        w[15:0] = 16'($urandom);
        w[17]   = ($urandom_range(0, 3) == 0);
        w[16]   = ($urandom_range(0, 2) == 0);
        push_word(w);
      end
      step();
    end
    drain(3000);
    ntot++; if (ErrCount !== CW'(exp_err)) $display("FAIL rand_err: got %0d want %0d", ErrCount, CW'(exp_err)); else npass++;
    ntot++; if (OutValid !== 1'b0) $display("FAIL rand_empty: got %b want 0", OutValid); else npass++;
  endtask

  initial begin
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_framing();
    test_truncation();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
